custom_matrix_pipe: RTL and testbench

//  Pipelined, programmable successor to the fixed 4-bit custom_matrix remap. CHANNELS lanes of WIDTH bits

---
 rtl/custom_matrix_pkg.sv | 7 +
 rtl/custom_matrix_round.sv | 34 +++
 rtl/custom_matrix_pipe.sv | 70 +++++++
 tb/tb_custom_matrix_pipe.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/custom_matrix_pkg.sv
// custom_matrix_pkg: pipeline FSM states and table reset helper shared by the remap pipe
package custom_matrix_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, CFG} state_t;
  function automatic int unsigned identity_init(input int unsigned i, input int unsigned w);
    return i % (32'd1 << w);
  endfunction
endpackage

// File: rtl/custom_matrix_round.sv
// custom_matrix_round: one pipeline stage (en, src_valid/bypass/data in, lut, valid/bypass/data out) applying the table lanewise
module custom_matrix_round import custom_matrix_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          src_valid,
  input  logic                          src_bypass,
  input  logic [CHANNELS*WIDTH-1:0]     src_data,
  input  logic [(2**WIDTH)*WIDTH-1:0]   lut,
  output logic                          valid,
  output logic                          bypass,
  output logic [CHANNELS*WIDTH-1:0]     data
);
  logic [CHANNELS*WIDTH-1:0] mapped;
  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    logic [WIDTH-1:0] lane;
    assign lane = src_data[c*WIDTH +: WIDTH];
    assign mapped[c*WIDTH +: WIDTH] = src_bypass ? lane : lut[lane*WIDTH +: WIDTH];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      bypass <= 1'b0;
      data <= '0;
    end else if (en) begin
      valid <= src_valid;
      bypass <= src_bypass;
      data <= mapped;
    end
  end
endmodule

// File: rtl/custom_matrix_pipe.sv
// custom_matrix_pipe: valid/ready lane remap through a writable table applied ROUNDS times, with drain-then-configure handshake
module custom_matrix_pipe import custom_matrix_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int CHANNELS = 2,
  parameter int ROUNDS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_bypass,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  input  logic                      cfg_req,
  output logic                      cfg_ack,
  input  logic                      cfg_we,
  input  logic [WIDTH-1:0]          cfg_addr,
  input  logic [WIDTH-1:0]          cfg_data
);
  localparam int CW = CHANNELS*WIDTH;
  localparam int N = 2**WIDTH;
  state_t state, state_nxt;
  logic [N*WIDTH-1:0] lut;
  logic [ROUNDS:0] v, b;
  logic [CW-1:0] d [ROUNDS+1];
  logic advance, busy;
  assign advance = !out_valid || out_ready;
  assign busy = |v[ROUNDS:1];
  assign v[0] = in_valid && in_ready;
  assign b[0] = in_bypass;
  assign d[0] = in_data;
  assign out_valid = v[ROUNDS];
  assign out_data = d[ROUNDS];
  for (genvar k = 0; k < ROUNDS; k++) begin : g_round
    custom_matrix_round #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) u_round (
      .clk(clk),
      .rst(rst),
      .en(advance),
      .src_valid(v[k]),
      .src_bypass(b[k]),
      .src_data(d[k]),
      .lut(lut),
      .valid(v[k+1]),
      .bypass(b[k+1]),
      .data(d[k+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == RUN ? (cfg_req ? DRAIN : RUN) :
                !cfg_req ? RUN :
                (state == DRAIN && busy) ? DRAIN : CFG;
  end
  always_comb begin
    in_ready = state == RUN && advance;
    cfg_ack = state == CFG;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) lut[i*WIDTH +: WIDTH] <= WIDTH'(identity_init(i, WIDTH));
    end else if (cfg_ack && cfg_we) begin
      lut[cfg_addr*WIDTH +: WIDTH] <= cfg_data;
    end
  end
endmodule

// File: tb/tb_custom_matrix_pipe.sv
// tb_custom_matrix_pipe: directed checks of remap, latency, backpressure, drain/config handshake and reset
module tb_custom_matrix_pipe;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_bypass = 0;
  logic [7:0] in_data = 0, out_data;
  logic out_valid, out_ready = 1;
  logic cfg_req = 0, cfg_ack, cfg_we = 0;
  logic [3:0] cfg_addr = 0, cfg_data = 0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  custom_matrix_pipe #(.WIDTH(4), .CHANNELS(2), .ROUNDS(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_req(cfg_req), .cfg_ack(cfg_ack), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic program_plus1();
    cfg_req = 1;
    for (int i = 0; i < 20 && !cfg_ack; i++) tick();
    chk("prog_ack", cfg_ack, 1);
    chk("prog_in_ready", in_ready, 0);
    for (int i = 0; i < 16; i++) begin
      cfg_we = 1;
      cfg_addr = 4'(i);
      cfg_data = 4'(i + 1);
      if (i == 15) cfg_req = 0;
      tick();
    end
    cfg_we = 0;
    chk("prog_ack_drop", cfg_ack, 0);
  endtask
  initial begin
    tick();
    tick();
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 1; in_data = 8'h3A;
    tick();
    in_valid = 0;
    chk("id_lat1", out_valid, 0);
    tick();
    chk("id_valid", out_valid, 1);
    chk("id_data", out_data, 8'h3A);
    tick();
    chk("id_one_cycle", out_valid, 0);
    program_plus1();
    chk("run_in_ready", in_ready, 1);
    in_valid = 1; in_data = 8'h3A;
    tick();
    in_data = 8'hFF;
    tick();
    chk("s0_valid", out_valid, 1);
    chk("s0_data", out_data, 8'h5C);
    in_data = 8'h0F;
    tick();
    chk("s1_data", out_data, 8'h11);
    in_valid = 0;
    tick();
    chk("s2_valid", out_valid, 1);
    chk("s2_data", out_data, 8'h21);
    tick();
    chk("s_end", out_valid, 0);
    in_valid = 1; in_data = 8'h3A; in_bypass = 1;
    tick();
    in_bypass = 0;
    tick();
    in_valid = 0;
    chk("byp_data", out_data, 8'h3A);
    tick();
    chk("nobyp_data", out_data, 8'h5C);
    tick();
    in_valid = 1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    chk("bp_first", out_data, 8'h33);
    out_ready = 0; in_data = 8'h44;
    #1;
    chk("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", out_data, 8'h33);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("bp_r0", out_data, 8'h44);
    tick();
    chk("bp_r1_valid", out_valid, 1);
    chk("bp_r1", out_data, 8'h66);
    tick();
    chk("bp_r2", out_valid, 0);
    in_valid = 1; in_data = 8'h12;
    tick();
    in_data = 8'h34;
    tick();
    chk("dr_b0", out_data, 8'h34);
    in_valid = 0; cfg_req = 1; cfg_we = 1; cfg_addr = 0; cfg_data = 4'hF;
    tick();
    chk("dr_in_ready", in_ready, 0);
    chk("dr_ack0", cfg_ack, 0);
    chk("dr_b1_valid", out_valid, 1);
    chk("dr_b1", out_data, 8'h56);
    in_valid = 1; in_data = 8'h00;
    tick();
    chk("dr_ack1", cfg_ack, 0);
    chk("dr_empty", out_valid, 0);
    chk("dr_in_ready2", in_ready, 0);
    tick();
    cfg_we = 0;
    chk("dr_ack2", cfg_ack, 1);
    chk("cfg_in_ready", in_ready, 0);
    chk("cfg_no_out", out_valid, 0);
    cfg_req = 0;
    tick();
    chk("cfg_exit", cfg_ack, 0);
    tick();
    in_valid = 0;
    chk("dr_no_leak", out_valid, 0);
    tick();
    chk("tbl0_valid", out_valid, 1);
    chk("tbl0_kept", out_data, 8'h22);
    tick();
    in_valid = 1; in_data = 8'h77;
    tick();
    in_valid = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_valid", out_valid, 0);
    tick();
    chk("rst_mid_drop", out_valid, 0);
    cfg_req = 1;
    for (int i = 0; i < 20 && !cfg_ack; i++) tick();
    chk("rst_cfg_in", cfg_ack, 1);
    rst = 1; cfg_we = 1; cfg_addr = 4'h3; cfg_data = 4'h9;
    tick();
    rst = 0; cfg_req = 0; cfg_we = 0;
    chk("rst_cfg_ack", cfg_ack, 0);
    chk("rst_cfg_valid", out_valid, 0);
    in_valid = 1; in_data = 8'h3A;
    tick();
    in_valid = 0;
    tick();
    chk("rst_tbl_valid", out_valid, 1);
    chk("rst_tbl_id", out_data, 8'h3A);
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
